norm_round_unit: RTL

Multi-cycle normalize-and-round stage that sits directly upstream of the FPU final-output stage. It accepts a raw, unnormalized mantissa and exponent from the adder/multiplier datapath. It normalizes the mantissa, rounds it to nearest-even, and classifies the result. It then hands the final-output stage `M_out`, `E_out`, `required_shift` and the overflow/underflow/invalid flags over a valid/ready handshake.

---
 rtl/norm_round_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/norm_round_unit.sv
// norm_round_unit: normalize-and-round stage ahead of the FPU final-output stage.
// Takes a raw 28-bit mantissa (carry, hidden, 23 fraction, guard/round/sticky)
// and a 10-bit signed biased exponent, normalizes, rounds to nearest-even and
// classifies the result, then hands it downstream over a valid/ready handshake.
// Optional build macro NORM_FAST_EN: normalize in a single cycle using a
// leading-zero count instead of shifting one bit per cycle.
module norm_round_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [27:0] in_mant,
  input  logic [9:0]  in_exp,
  input  logic        in_invalid,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [22:0] M_out,
  output logic [7:0]  E_out,
  output logic [4:0]  required_shift,
  output logic        overflow_flag,
  output logic        underflow_flag,
  output logic        invalid_flag
);

  typedef enum logic [1:0] {IDLE, NORM, ROUND, OUT} state_t;

  state_t state, state_next;

  logic [27:0]        m;
  logic signed [9:0]  e;
  logic               inv_q;

  logic [27:0]        m_norm;
  logic signed [9:0]  e_norm;
  logic               norm_done;

  logic               round_up;
  logic [27:0]        m_sum;
  logic [27:0]        m_rnd;
  logic signed [9:0]  e_rnd;
  logic [10:0]        den_shift;

  logic [22:0]        m_out_next;
  logic [7:0]         e_out_next;
  logic [4:0]         shift_next;
  logic               of_next;
  logic               uf_next;
  logic               iv_next;

`ifdef NORM_FAST_EN
  // Leading-zero count of the 27 bits at and below the hidden-bit position.
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lzc27 = 5'(26 - i);
    end
  endfunction
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state selection; NORM repeats until the hidden bit is in place or m is zero.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = NORM;
      NORM:    if (norm_done) state_next = ROUND;
      ROUND:   state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake output decode: operands are accepted only while idle.
  always_comb begin
    in_ready = (state == IDLE);
  end

  // One normalization step: carry fold-down with sticky, or left shift toward bit 26.
  always_comb begin
    m_norm    = m;
    e_norm    = e;
    norm_done = 1'b1;
    if (m[27]) begin
      m_norm = {1'b0, m[27:2], m[1] | m[0]};
      e_norm = e + 10'sd1;
    end else if (!m[26] && (m != 28'd0)) begin
`ifdef NORM_FAST_EN
      m_norm = m << lzc27(m[26:0]);
      e_norm = e - {5'd0, lzc27(m[26:0])};
`else
      m_norm    = {m[26:0], 1'b0};
      e_norm    = e - 10'sd1;
      norm_done = 1'b0;
`endif
    end
  end

  // Round to nearest-even at bit 3, renormalize on carry-out, then classify.
  always_comb begin
    round_up = m[2] & (m[1] | m[0] | m[3]);
    m_sum    = m + {24'd0, round_up, 3'b000};
    m_rnd    = m_sum;
    e_rnd    = e;
    if (m_sum[27]) begin
      m_rnd = {1'b0, m_sum[27:1]};
      e_rnd = e + 10'sd1;
    end
    den_shift = 11'd1 - {e_rnd[9], e_rnd};

    m_out_next = 23'd0;
    e_out_next = 8'd0;
    shift_next = 5'd0;
    of_next    = 1'b0;
    uf_next    = 1'b0;
    iv_next    = 1'b0;
    if (inv_q) begin
      iv_next = 1'b1;
    end else if (m_rnd == 28'd0) begin
      iv_next = 1'b0;
    end else if (e_rnd >= 10'sd255) begin
      of_next    = 1'b1;
      e_out_next = 8'hFF;
    end else if (e_rnd <= 10'sd0) begin
      uf_next    = 1'b1;
      m_out_next = m_rnd[25:3];
      shift_next = (den_shift > 11'd31) ? 5'd31 : den_shift[4:0];
    end else begin
      m_out_next = m_rnd[25:3];
      e_out_next = e_rnd[7:0];
    end
  end

  // Working registers and registered outputs, advanced according to the current state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m              <= 28'd0;
      e              <= 10'sd0;
      inv_q          <= 1'b0;
      out_valid      <= 1'b0;
      M_out          <= 23'd0;
      E_out          <= 8'd0;
      required_shift <= 5'd0;
      overflow_flag  <= 1'b0;
      underflow_flag <= 1'b0;
      invalid_flag   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            m     <= in_mant;
            e     <= $signed(in_exp);
            inv_q <= in_invalid;
          end
        end
        NORM: begin
          m <= m_norm;
          e <= e_norm;
        end
        ROUND: begin
          M_out          <= m_out_next;
          E_out          <= e_out_next;
          required_shift <= shift_next;
          overflow_flag  <= of_next;
          underflow_flag <= uf_next;
          invalid_flag   <= iv_next;
          out_valid      <= 1'b1;
        end
        OUT: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: out_valid <= 1'b0;
      endcase
    end
  end

endmodule
